matrix_scan_driver: RTL and testbench
=====================================

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 SHALL have parameter ROW_TICKS, default 25000: CLK cycles each column is lit.
REQ-002 SHALL have parameter BLANK_TICKS, default 2: CLK cycles all LEDs are off between columns (anti-ghosting).
REQ-003 CLK  in  1  system clock; all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  pixel write request to back buffer.
REQ-006 wr_x  in  3  pixel column 0..7.
REQ-007 wr_y  in  3  pixel row 0..7.
REQ-008 wr_rgb  in  3  color, bit0 R, bit1 G, bit2 B; 1 = lit.
REQ-009 wr_ready  out  1  high = write/clear/swap request accepted this cycle.
REQ-010 clr  in  1  single-cycle request: clear back buffer.
REQ-011 swap_req  in  1  level request: present back buffer at next frame boundary; held until swap_ack.
REQ-012 swap_ack  out  1  one-cycle pulse when swap is performed.
REQ-013 frame_start  out  1  one-cycle pulse on first lit cycle of column 0.
REQ-014 rgb_com  out  4  {enable, column[2:0]}; enable=1 drives the column.
REQ-015 DATA_R, DATA_G, DATA_B  out  8 each  active-low row data, bit y = row y of the driven column.

Function
REQ-016 Two 8x8x3 buffers SHALL exist: front (scanned) and back (written); writes never touch front.
REQ-017 Scan FSM SHALL have states SHOW and BLANK; SHOW lasts ROW_TICKS cycles, BLANK lasts BLANK_TICKS cycles, then column increments mod 8 (7 -> 0) and state returns to SHOW.
REQ-018 In SHOW, rgb_com SHALL be {1, col} and DATA_c[y] SHALL equal ~front[col][y].c (registered, no extra latency beyond the state register).
REQ-019 In BLANK, rgb_com[3] SHALL be 0 and DATA_R/G/B SHALL be 8'hFF.
REQ-020 frame_start SHALL pulse for exactly one cycle at entry to SHOW of column 0.
REQ-021 Swap SHALL occur only on the last BLANK cycle after column 7 while swap_req is high and no clear is in progress; swap_ack pulses that same cycle; new front is scanned from the following column 0.
REQ-022 swap_req asserted during column 7 BLANK but after its last cycle SHALL wait one full frame.
REQ-023 A write with wr_en & wr_ready SHALL update back[wr_x][wr_y] on that edge; writes with wr_ready low SHALL be dropped.
REQ-024 A write accepted in the swap cycle SHALL land in the pre-swap back buffer and therefore appear in the new front.
REQ-025 clr accepted SHALL clear back buffer one column per cycle, columns 0..7, 8 cycles; wr_ready SHALL be low during those 8 cycles and return high the next cycle.
REQ-026 clr and wr_en in the same accepted cycle: clear wins, write dropped.
REQ-027 clr with wr_ready low SHALL be ignored; swap_req pending during clear SHALL be deferred to the first frame boundary after clear completes.
REQ-028 Scanning SHALL never stall for writes, clears or swaps.

Reset
REQ-029 On RST: both buffers all-off, col=0, state SHOW with dwell counter 0, rgb_com=4'b0000, DATA_R/G/B=8'hFF, swap_ack=0, frame_start=0, wr_ready=0, clear idle.
REQ-030 First cycle after RST release SHALL be SHOW column 0 with frame_start pulse; wr_ready=1 from that cycle.
REQ-031 RST mid-clear or mid-swap SHALL abort it; no partial state survives.

Structure
REQ-032 Package snake_pkg SHALL hold color bit indices (R=0,G=1,B=2), MATRIX_DIM=8, and the scan-state enum.
REQ-033 Buffer pair plus swap select SHALL be sub-module frame_buffer; scan FSM and handshake stay in matrix_scan_driver.

Verification (ROW_TICKS=4, BLANK_TICKS=1)
REQ-034 Reset release -> rgb_com 8,9..F each 4 cycles with 1-cycle gaps of rgb_com[3]=0, DATA all FF throughout, frame_start every 40 cycles.
REQ-035 Write (3,5,rgb=3'b001), swap_req high -> swap_ack at last BLANK of col 7; next col 3 SHOW: DATA_R=8'hDF, DATA_G=DATA_B=8'hFF.
REQ-036 Write pixel, no swap_req -> display unchanged for 3 frames.
REQ-037 clr then wr_en every cycle -> wr_ready low 8 cycles, those writes absent after swap; write on 9th cycle present.
REQ-038 swap_req raised during clear spanning a frame boundary -> no swap_ack that boundary; ack at next boundary.
REQ-039 RST pulsed mid-frame with lit pixels -> outputs FF/0000 immediately (asynchronous), display all-off after release until new write+swap.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the LED matrix scan driver:
// color bit positions, matrix size and the scan FSM states.
package snake_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int COL_W      = 3;
    localparam int NUM_COLORS = 3;

    localparam int COLOR_R = 0;
    localparam int COLOR_G = 1;
    localparam int COLOR_B = 2;

    typedef logic [NUM_COLORS-1:0] rgb_t;

    typedef enum logic {
        SCAN_SHOW  = 1'b0,
        SCAN_BLANK = 1'b1
    } scan_state_e;

endpackage

// File: rtl/frame_buffer.sv
// Double-buffered 8x8 RGB pixel store: writes/clears hit the back buffer,
// the scanner reads the front buffer, and a swap exchanges their roles.
module frame_buffer
    import snake_pkg::*;
(
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  wr_en,
    input  logic [COL_W-1:0]                      wr_x,
    input  logic [COL_W-1:0]                      wr_y,
    input  rgb_t                                  wr_rgb,
    input  logic                                  clr_en,
    input  logic [COL_W-1:0]                      clr_col,
    input  logic                                  swap,
    input  logic [COL_W-1:0]                      rd_col,
    output logic [NUM_COLORS-1:0][MATRIX_DIM-1:0] rd_planes
);

    typedef rgb_t    [MATRIX_DIM-1:0] column_t;
    typedef column_t [MATRIX_DIM-1:0] plane_t;

    plane_t [1:0] buf_q;
    plane_t [1:0] buf_d;
    logic         sel_q;
    logic         sel_d;
    logic         back_sel;

    assign back_sel = ~sel_q;

    always_comb begin
        buf_d = buf_q;
        sel_d = sel_q;
        if (clr_en) begin
            buf_d[back_sel][clr_col] = '0;
        end else if (wr_en) begin
            buf_d[back_sel][wr_x][wr_y] = wr_rgb;
        end
        if (swap) begin
            sel_d = back_sel;
        end
    end

    // Read the post-edge contents so a write landing in the swap cycle is
    // already visible when the new front is first scanned.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_COLORS; gi++) begin : g_color
            for (gj = 0; gj < MATRIX_DIM; gj++) begin : g_row
                assign rd_planes[gi][gj] = buf_d[sel_d][rd_col][gj][gi];
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_q <= '0;
            sel_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed 8x8 RGB LED matrix driver with a blanking gap between
// columns, a pixel write port, a back-buffer clear engine and frame swaps.
module matrix_scan_driver
    import snake_pkg::*;
#(
    parameter int ROW_TICKS   = 25000,
    parameter int BLANK_TICKS = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [COL_W-1:0]      wr_x,
    input  logic [COL_W-1:0]      wr_y,
    input  logic [NUM_COLORS-1:0] wr_rgb,
    output logic                  wr_ready,
    input  logic                  clr,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  frame_start,
    output logic [3:0]            rgb_com,
    output logic [MATRIX_DIM-1:0] DATA_R,
    output logic [MATRIX_DIM-1:0] DATA_G,
    output logic [MATRIX_DIM-1:0] DATA_B
);

    localparam int DWELL_MAX = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int CNT_W     = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(ROW_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(MATRIX_DIM - 1);

    scan_state_e                          state_q, state_d;
    logic [COL_W-1:0]                     col_q, col_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 started_q;
    logic                                 clr_busy_q, clr_busy_d;
    logic [COL_W-1:0]                     clr_col_q, clr_col_d;
    logic                                 wr_ready_q, wr_ready_d;
    logic                                 frame_start_q, frame_start_d;
    logic [3:0]                           rgb_com_q, rgb_com_d;
    logic [NUM_COLORS-1:0][MATRIX_DIM-1:0] data_q, data_d;
    logic [NUM_COLORS-1:0][MATRIX_DIM-1:0] rd_planes;

    logic last_blank;
    logic clr_accept;
    logic wr_accept;
    logic swap_go;

    // The first edge after reset only loads the outputs for column 0, so the
    // first column still gets its full dwell.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        if (started_q) begin
            case (state_q)
                SCAN_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = SCAN_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SCAN_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SCAN_SHOW;
                        cnt_d   = '0;
                        col_d   = col_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign last_blank = (state_q == SCAN_BLANK) && (col_q == LAST_COL) && (cnt_q == BLANK_LAST);
    assign clr_accept = clr && wr_ready_q;
    assign wr_accept  = wr_en && wr_ready_q && !clr;
    assign swap_go    = last_blank && swap_req && wr_ready_q && !clr;

    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_col_d  = clr_col_q;
        if (clr_accept) begin
            clr_busy_d = 1'b1;
            clr_col_d  = '0;
        end else if (clr_busy_q) begin
            clr_col_d = clr_col_q + 1'b1;
            if (clr_col_q == LAST_COL) begin
                clr_busy_d = 1'b0;
            end
        end
        wr_ready_d = !clr_busy_d;
    end

    frame_buffer u_frame_buffer (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (wr_accept),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_rgb    (wr_rgb),
        .clr_en    (clr_busy_q),
        .clr_col   (clr_col_q),
        .swap      (swap_go),
        .rd_col    (col_d),
        .rd_planes (rd_planes)
    );

    always_comb begin
        frame_start_d = (state_d == SCAN_SHOW) && (col_d == '0) && (cnt_d == '0);
        rgb_com_d     = {state_d == SCAN_SHOW, col_d};
        for (int c = 0; c < NUM_COLORS; c++) begin
            data_d[c] = (state_d == SCAN_SHOW) ? ~rd_planes[c] : '1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= SCAN_SHOW;
            col_q         <= '0;
            cnt_q         <= '0;
            started_q     <= 1'b0;
            clr_busy_q    <= 1'b0;
            clr_col_q     <= '0;
            wr_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_com_q     <= 4'b0000;
            data_q        <= '1;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            started_q     <= 1'b1;
            clr_busy_q    <= clr_busy_d;
            clr_col_q     <= clr_col_d;
            wr_ready_q    <= wr_ready_d;
            frame_start_q <= frame_start_d;
            rgb_com_q     <= rgb_com_d;
            data_q        <= data_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign swap_ack    = swap_go;
    assign frame_start = frame_start_q;
    assign rgb_com     = rgb_com_q;
    assign DATA_R      = data_q[COLOR_R];
    assign DATA_G      = data_q[COLOR_G];
    assign DATA_B      = data_q[COLOR_B];

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Randomized bench for matrix_scan_driver against a frame-position model:
// scan timing from cycle arithmetic, buffers as plain arrays.
module tb_matrix_scan_driver;

    localparam int ROW_T   = 4;
    localparam int BLANK_T = 1;
    localparam int COL_T   = ROW_T + BLANK_T;
    localparam int FRAME_T = 8 * COL_T;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_x = '0;
    logic [2:0] wr_y = '0;
    logic [2:0] wr_rgb = '0;
    logic       wr_ready;
    logic       clr = 1'b0;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       frame_start;
    logic [3:0] rgb_com;
    logic [7:0] DATA_R, DATA_G, DATA_B;

    always #5 CLK = ~CLK;

    matrix_scan_driver #(
        .ROW_TICKS   (ROW_T),
        .BLANK_TICKS (BLANK_T)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_rgb      (wr_rgb),
        .wr_ready    (wr_ready),
        .clr         (clr),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .rgb_com     (rgb_com),
        .DATA_R      (DATA_R),
        .DATA_G      (DATA_G),
        .DATA_B      (DATA_B)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [2:0] m_front [8][8];
    logic [2:0] m_back  [8][8];
    int         m_k;
    int         m_clear_left;
    bit         last_swap;
    bit         last_ack_obs;
    bit         last_ready_obs;
    bit         probe_px;

    // Stimulus for the next cycle
    logic       d_we = 1'b0, d_clr = 1'b0, d_sr = 1'b0;
    logic [2:0] d_x = '0, d_y = '0, d_rgb = '0;

    task automatic model_reset();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                m_front[x][y] = '0;
                m_back[x][y]  = '0;
            end
        m_k          = 0;
        m_clear_left = 0;
        last_swap    = 1'b0;
    endtask

    task automatic drive_idle();
        d_we = 1'b0; d_clr = 1'b0; d_sr = 1'b0;
        wr_en = 1'b0; clr = 1'b0; swap_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rgb_com"}, 32'(rgb_com), 32'(0));
        check_val({tag, "_data_r"}, 32'(DATA_R), 32'(8'hFF));
        check_val({tag, "_data_g"}, 32'(DATA_G), 32'(8'hFF));
        check_val({tag, "_data_b"}, 32'(DATA_B), 32'(8'hFF));
        check_val({tag, "_frame_start"}, 32'(frame_start), 32'(0));
        check_val({tag, "_wr_ready"}, 32'(wr_ready), 32'(0));
        check_val({tag, "_swap_ack"}, 32'(swap_ack), 32'(0));
    endtask

    // Called with RST high; releases it so the next rising edge starts cycle 0.
    task automatic release_reset();
        @(negedge CLK);
        check_reset_outputs("rst");
        RST = 1'b0;
        model_reset();
        @(posedge CLK);
    endtask

    task automatic cycle();
        int pos, col;
        bit show, ready, clr_acc, wr_acc, swp;
        logic [7:0] er, eg, eb;
        logic [2:0] tmp;
        @(negedge CLK);
        wr_en = d_we; wr_x = d_x; wr_y = d_y; wr_rgb = d_rgb;
        clr = d_clr; swap_req = d_sr;
        #1;
        pos     = m_k % FRAME_T;
        col     = pos / COL_T;
        show    = (pos % COL_T) < ROW_T;
        ready   = (m_clear_left == 0);
        clr_acc = d_clr && ready;
        wr_acc  = d_we && ready && !d_clr;
        swp     = (pos == FRAME_T - 1) && d_sr && ready && !d_clr;
        for (int y = 0; y < 8; y++) begin
            er[y] = show ? ~m_front[col][y][0] : 1'b1;
            eg[y] = show ? ~m_front[col][y][1] : 1'b1;
            eb[y] = show ? ~m_front[col][y][2] : 1'b1;
        end
        check_val("rgb_en", 32'(rgb_com[3]), 32'(show));
        if (show) check_val("rgb_col", 32'(rgb_com[2:0]), 32'(col));
        check_val("data_r", 32'(DATA_R), 32'(er));
        check_val("data_g", 32'(DATA_G), 32'(eg));
        check_val("data_b", 32'(DATA_B), 32'(eb));
        check_val("frame_start", 32'(frame_start), 32'(pos == 0));
        check_val("wr_ready", 32'(wr_ready), 32'(ready));
        check_val("swap_ack", 32'(swap_ack), 32'(swp));
        if (probe_px && show && col == 3) begin
            check_val("probe_r", 32'(DATA_R), 32'(8'hDF));
            check_val("probe_g", 32'(DATA_G), 32'(8'hFF));
            check_val("probe_b", 32'(DATA_B), 32'(8'hFF));
            probe_px = 1'b0;
        end
        last_ack_obs   = swap_ack;
        last_ready_obs = wr_ready;
        @(posedge CLK);
        if (m_clear_left > 0) begin
            for (int y = 0; y < 8; y++) m_back[8 - m_clear_left][y] = '0;
            m_clear_left--;
        end else if (clr_acc) begin
            m_clear_left = 8;
            $display("[TB] k=%0d clear accepted", m_k);
        end else if (wr_acc) begin
            m_back[d_x][d_y] = d_rgb;
            $display("[TB] k=%0d write x=%0d y=%0d rgb=%0d", m_k, d_x, d_y, d_rgb);
        end
        if (swp) begin
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    tmp           = m_front[x][y];
                    m_front[x][y] = m_back[x][y];
                    m_back[x][y]  = tmp;
                end
            $display("[TB] k=%0d swap performed", m_k);
        end
        last_swap = swp;
        m_k++;
    endtask

    task automatic swap_until_ack(input string tag);
        int n;
        d_sr = 1'b1;
        last_swap = 1'b0;
        n = 0;
        while (!last_swap && n < 4 * FRAME_T) begin
            cycle();
            n++;
        end
        check_val(tag, 32'(last_ack_obs), 32'(1));
        d_sr = 1'b0;
    endtask

    task automatic write_px(input int x, input int y, input int rgb);
        d_we = 1'b1; d_x = 3'(x); d_y = 3'(y); d_rgb = 3'(rgb);
        cycle();
        d_we = 1'b0;
    endtask

    initial begin
        int low_cnt, ack_wait, guard;
        model_reset();
        probe_px = 1'b0;
        drive_idle();
        repeat (2) @(posedge CLK);
        release_reset();

        // Free-running scan with nothing written
        repeat (2 * FRAME_T) cycle();

        // Single red pixel, then swap; column 3 row 5 lit red
        write_px(3, 5, 3'b001);
        swap_until_ack("swap_single_px");
        probe_px = 1'b1;
        repeat (FRAME_T) cycle();

        // Write without swap leaves the display untouched
        write_px(6, 1, 3'b110);
        repeat (3 * FRAME_T) cycle();

        // Clear followed by continuous writes
        d_clr = 1'b1; d_we = 1'b1; d_x = 3'd2; d_y = 3'd2; d_rgb = 3'd7;
        cycle();
        d_clr = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            d_x = 3'($urandom_range(0, 7)); d_y = 3'($urandom_range(0, 7));
            d_rgb = 3'($urandom_range(1, 7));
            cycle();
            if (!last_ready_obs) low_cnt++;
        end
        d_we = 1'b0;
        check_val("clr_ready_low_cycles", 32'(low_cnt), 32'(8));
        swap_until_ack("swap_after_clear");
        repeat (FRAME_T) cycle();

        // Swap request raised while a clear spans the frame boundary
        guard = 0;
        while ((m_k % FRAME_T) != 35 && guard < 2 * FRAME_T) begin
            cycle();
            guard++;
        end
        d_clr = 1'b1;
        cycle();
        d_clr = 1'b0;
        d_sr = 1'b1;
        ack_wait = 0;
        do begin
            cycle();
            ack_wait++;
        end while (!last_ack_obs && ack_wait < 4 * FRAME_T);
        d_sr = 1'b0;
        check_val("deferred_swap_wait", 32'(ack_wait), 32'(FRAME_T + 4));

        // Randomized traffic
        for (int i = 0; i < 12 * FRAME_T; i++) begin
            d_we  = 1'($urandom_range(0, 1));
            d_x   = 3'($urandom_range(0, 7));
            d_y   = 3'($urandom_range(0, 7));
            d_rgb = 3'($urandom_range(0, 7));
            d_clr = ($urandom_range(0, 59) == 0);
            if (!d_sr) d_sr = ($urandom_range(0, 29) == 0);
            cycle();
            if (last_swap) d_sr = 1'b0;
        end
        d_we = 1'b0; d_clr = 1'b0; d_sr = 1'b0;

        // Make sure the front has lit pixels, start a clear, then reset mid-frame
        write_px(0, 0, 3'b111);
        swap_until_ack("swap_before_reset");
        repeat (7) cycle();
        d_clr = 1'b1;
        cycle();
        d_clr = 1'b0;
        repeat (3) cycle();
        @(negedge CLK);
        drive_idle();
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge CLK);
        release_reset();
        repeat (2 * FRAME_T) cycle();
        write_px(7, 7, 3'b010);
        write_px(0, 3, 3'b100);
        swap_until_ack("swap_after_reset");
        repeat (FRAME_T + 5) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
